// File: rtl/bram_bank_loader_pkg.sv
// Shared parsing geometry: bank count, bank depth, address/data widths and
// the loader FSM state encoding used by the BRAM bank loader.
package bram_bank_loader_pkg;

    // Bank geometry shared with the parsing block that reads these BRAMs.
    localparam int PARSE_NUM_BANK   = 16;
    localparam int PARSE_BANK_DEPTH = 128;
    localparam int PARSE_ADDR_W     = 9;
    localparam int PARSE_DATA_W     = 128;
    localparam int PARSE_GAP_CYC    = 10;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } loaderState_t;

endpackage

// File: rtl/bram_bank_loader.sv
// BRAM bank loader: streams source words into NUM_BANK banks in order
// (bank 0 addr 0 .. bank NUM_BANK-1 addr BANK_DEPTH-1). Every write is
// registered. After the final write and GAP_CYC idle cycles, a single-cycle
// oStart pulse kicks off the parsing block.
module bram_bank_loader
    import bram_bank_loader_pkg::*;
#(
    parameter int NUM_BANK   = PARSE_NUM_BANK,
    parameter int BANK_DEPTH = PARSE_BANK_DEPTH,
    parameter int GAP_CYC    = PARSE_GAP_CYC
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    iLoad,
    input  logic                    iValid,
    input  logic [PARSE_DATA_W-1:0] iData,
    output logic                    oReady,
    output logic [NUM_BANK-1:0]     o_ena,
    output logic [NUM_BANK-1:0]     o_wea,
    output logic [PARSE_ADDR_W-1:0] o_addra,
    output logic [PARSE_DATA_W-1:0] o_dia,
    output logic                    oBusy,
    output logic                    oStart
);

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    loaderState_t              state;
    loaderState_t              stateNext;
    logic [BANK_W-1:0]         bankCnt;
    logic [PARSE_ADDR_W-1:0]   addrCnt;
    logic [GAP_W-1:0]          gapCnt;
    logic                      accept;
    logic                      lastAddr;
    logic                      lastWord;
    logic                      gapDone;

    // A word is taken only while loading and the source presents valid data.
    assign accept   = (state == LOAD) && iValid;
    assign lastAddr = (addrCnt == PARSE_ADDR_W'(BANK_DEPTH - 1));
    assign lastWord = lastAddr && (bankCnt == BANK_W'(NUM_BANK - 1));
    assign gapDone  = (gapCnt == GAP_W'(GAP_CYC - 1));

    // State register; reset abandons any load in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and state-decoded handshake/status outputs.
    always_comb begin
        stateNext = state;
        oReady    = 1'b0;
        oBusy     = 1'b1;
        oStart    = 1'b0;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iLoad) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                oReady = 1'b1;
                if (accept && lastWord) begin
                    stateNext = GAP;
                end
            end
            GAP: begin
                if (gapDone) begin
                    stateNext = START;
                end
            end
            START: begin
                oStart    = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Bank/address counters: cleared when a load begins, advanced per accepted word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bankCnt <= '0;
            addrCnt <= '0;
        end else if ((state == IDLE) && iLoad) begin
            bankCnt <= '0;
            addrCnt <= '0;
        end else if (accept) begin
            if (lastWord) begin
                bankCnt <= '0;
                addrCnt <= '0;
            end else if (lastAddr) begin
                bankCnt <= bankCnt + BANK_W'(1);
                addrCnt <= '0;
            end else begin
                addrCnt <= addrCnt + PARSE_ADDR_W'(1);
            end
        end
    end

    // Gap counter runs only in GAP so the START pulse lands GAP_CYC cycles after the last write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gapCnt <= '0;
        end else if (state == GAP) begin
            gapCnt <= gapCnt + GAP_W'(1);
        end else begin
            gapCnt <= '0;
        end
    end

    // Registered BRAM write port: enables pulse for one cycle per accepted word, address/data hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_ena   <= '0;
            o_wea   <= '0;
            o_addra <= '0;
            o_dia   <= '0;
        end else if (accept) begin
            o_ena   <= NUM_BANK'(1) << bankCnt;
            o_wea   <= NUM_BANK'(1) << bankCnt;
            o_addra <= addrCnt;
            o_dia   <= iData;
        end else begin
            o_ena   <= '0;
            o_wea   <= '0;
        end
    end

endmodule

// File: tb/tb_bram_bank_loader.sv
// Directed bench for bram_bank_loader: full loads, stalls, ignored load
// requests, mid-load reset with a BRAM content scoreboard, and a GAP_CYC=1
// instance with a small geometry.
`timescale 1ns/1ps
module tb_bram_bank_loader;

    localparam int TOTAL = 2048;

    logic         clk;
    logic         rstn;
    logic         iLoad;
    logic         iValid;
    logic [127:0] iData;
    logic         oReady;
    logic [15:0]  o_ena;
    logic [15:0]  o_wea;
    logic [8:0]   o_addra;
    logic [127:0] o_dia;
    logic         oBusy;
    logic         oStart;

    logic         iLoad2;
    logic         iValid2;
    logic [127:0] iData2;
    logic         oReady2;
    logic [1:0]   o_ena2;
    logic [1:0]   o_wea2;
    logic [8:0]   o_addra2;
    logic [127:0] o_dia2;
    logic         oBusy2;
    logic         oStart2;

    int checks = 0;
    int errors = 0;

    int writeCount = 0;
    int startCount = 0;
    int shapeBad   = 0;
    int monIdx;
    logic [127:0] mem [0:TOTAL-1];
    logic [127:0] src [0:TOTAL-1];

    bram_bank_loader dut (
        .clk     (clk),
        .rstn    (rstn),
        .iLoad   (iLoad),
        .iValid  (iValid),
        .iData   (iData),
        .oReady  (oReady),
        .o_ena   (o_ena),
        .o_wea   (o_wea),
        .o_addra (o_addra),
        .o_dia   (o_dia),
        .oBusy   (oBusy),
        .oStart  (oStart)
    );

    bram_bank_loader #(.NUM_BANK(2), .BANK_DEPTH(4), .GAP_CYC(1)) dutGap1 (
        .clk     (clk),
        .rstn    (rstn),
        .iLoad   (iLoad2),
        .iValid  (iValid2),
        .iData   (iData2),
        .oReady  (oReady2),
        .o_ena   (o_ena2),
        .o_wea   (o_wea2),
        .o_addra (o_addra2),
        .o_dia   (o_dia2),
        .oBusy   (oBusy2),
        .oStart  (oStart2)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive BRAM model: captures every write of the default instance.
    always @(negedge clk) begin
        if (|o_wea) begin
            writeCount++;
            monIdx = -1;
            for (int i = 0; i < 16; i++) begin
                if (o_wea[i]) monIdx = i;
            end
            if (!$onehot(o_wea) || (o_ena !== o_wea) || (o_addra >= 9'd128)) begin
                shapeBad++;
            end else begin
                mem[monIdx * 128 + int'(o_addra)] = o_dia;
            end
        end
        if (oStart === 1'b1) startCount++;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic valid, input logic [127:0] data);
        iLoad  = load;
        iValid = valid;
        iData  = data;
    endtask

    function automatic logic [127:0] dataOf(input int k, input bit useSrc);
        if (useSrc) return src[k];
        return 128'(k);
    endfunction

    // Pulse iLoad from IDLE and confirm the loader enters LOAD.
    task automatic startLoad(input string tag);
        applyStimulus(1'b1, 1'b0, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput({tag, "_ready"}, 128'(oReady), 128'(1));
        checkOutput({tag, "_busy"}, 128'(oBusy), 128'(1));
    endtask

    // Feed words 0..count-1, checking each registered write and optional stall cycles.
    task automatic feedWords(input int count, input bit alternate, input int loadPulseAt,
                             input bit useSrc, output int bad);
        logic [15:0] expEna;
        bad = 0;
        for (int k = 0; k < count; k++) begin
            applyStimulus(k == loadPulseAt, 1'b1, dataOf(k, useSrc));
            @(negedge clk);
            expEna = 16'(1) << (k / 128);
            if ((o_wea !== expEna) || (o_ena !== expEna) ||
                (o_addra !== 9'(k % 128)) || (o_dia !== dataOf(k, useSrc))) begin
                bad++;
            end
            if (k == 0) begin
                checkOutput("first_ena", 128'(o_ena), 128'h0001);
                checkOutput("first_addr", 128'(o_addra), 128'(0));
            end
            if (k == 128) begin
                checkOutput("bank1_ena", 128'(o_ena), 128'h0002);
                checkOutput("bank1_wea", 128'(o_wea), 128'h0002);
                checkOutput("bank1_addr", 128'(o_addra), 128'(0));
                checkOutput("bank1_dia", o_dia, dataOf(128, useSrc));
            end
            applyStimulus(1'b0, 1'b0, '0);
            if (alternate && (k != count - 1)) begin
                @(negedge clk);
                if ((o_wea !== 16'h0) || (o_ena !== 16'h0) ||
                    (o_addra !== 9'(k % 128)) || (o_dia !== dataOf(k, useSrc))) begin
                    bad++;
                end
            end
        end
    endtask

    // From the cycle showing the final write, expect oStart exactly gap cycles later.
    task automatic runGap(input int gap, input bit pulseLoadAtStart);
        int bad = 0;
        for (int c = 1; c <= gap; c++) begin
            @(negedge clk);
            if (c < gap) begin
                if ((oStart !== 1'b0) || (o_wea !== 16'h0) || (oBusy !== 1'b1)) bad++;
            end else begin
                checkOutput("start_pulse", 128'(oStart), 128'(1));
                checkOutput("start_wea", 128'(o_wea), 128'(0));
                if (pulseLoadAtStart) iLoad = 1'b1;
            end
        end
        checkOutput("gap_quiet", 128'(bad), 128'(0));
        @(negedge clk);
        iLoad = 1'b0;
        checkOutput("start_clear", 128'(oStart), 128'(0));
        checkOutput("idle_busy", 128'(oBusy), 128'(0));
    endtask

    initial begin
        int bad;
        int baseW;
        int baseS;
        logic [1:0] expEna2;

        rstn    = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        iLoad2  = 1'b0;
        iValid2 = 1'b0;
        iData2  = '0;
        for (int i = 0; i < TOTAL; i++) src[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ena", 128'(o_ena), 128'(0));
        checkOutput("rst_wea", 128'(o_wea), 128'(0));
        checkOutput("rst_addra", 128'(o_addra), 128'(0));
        checkOutput("rst_dia", o_dia, 128'(0));
        checkOutput("rst_ready", 128'(oReady), 128'(0));
        checkOutput("rst_busy", 128'(oBusy), 128'(0));
        checkOutput("rst_start", 128'(oStart), 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] full load, no stalls");
        baseW = writeCount;
        baseS = startCount;
        startLoad("full");
        feedWords(TOTAL, 1'b0, -1, 1'b0, bad);
        checkOutput("full_seq", 128'(bad), 128'(0));
        checkOutput("full_ready_after", 128'(oReady), 128'(0));
        runGap(10, 1'b0);
        checkOutput("full_writes", 128'(writeCount - baseW), 128'(TOTAL));
        checkOutput("full_starts", 128'(startCount - baseS), 128'(1));

        $display("[TB] alternating iValid");
        baseW = writeCount;
        startLoad("alt");
        feedWords(TOTAL, 1'b1, -1, 1'b0, bad);
        checkOutput("alt_seq", 128'(bad), 128'(0));
        runGap(10, 1'b0);
        checkOutput("alt_writes", 128'(writeCount - baseW), 128'(TOTAL));

        $display("[TB] iLoad mid-LOAD and during START");
        baseW = writeCount;
        baseS = startCount;
        startLoad("reload");
        feedWords(TOTAL, 1'b0, 700, 1'b0, bad);
        checkOutput("reload_seq", 128'(bad), 128'(0));
        runGap(10, 1'b1);
        checkOutput("reload_ready", 128'(oReady), 128'(0));
        repeat (15) @(negedge clk);
        checkOutput("reload_idle", 128'(oBusy), 128'(0));
        checkOutput("reload_writes", 128'(writeCount - baseW), 128'(TOTAL));
        checkOutput("reload_starts", 128'(startCount - baseS), 128'(1));

        $display("[TB] reset mid-load");
        baseW = writeCount;
        baseS = startCount;
        startLoad("pre");
        feedWords(300, 1'b0, -1, 1'b0, bad);
        checkOutput("pre_seq", 128'(bad), 128'(0));
        applyStimulus(1'b0, 1'b1, '1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_ena", 128'(o_ena), 128'(0));
        checkOutput("mid_rst_wea", 128'(o_wea), 128'(0));
        checkOutput("mid_rst_addra", 128'(o_addra), 128'(0));
        checkOutput("mid_rst_dia", o_dia, 128'(0));
        checkOutput("mid_rst_ready", 128'(oReady), 128'(0));
        checkOutput("mid_rst_busy", 128'(oBusy), 128'(0));
        checkOutput("mid_rst_start", 128'(oStart), 128'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_writes", 128'(writeCount - baseW), 128'(300));
        checkOutput("post_rst_starts", 128'(startCount - baseS), 128'(0));
        checkOutput("post_rst_busy", 128'(oBusy), 128'(0));
        applyStimulus(1'b0, 1'b0, '0);

        baseW = writeCount;
        baseS = startCount;
        startLoad("sb");
        feedWords(TOTAL, 1'b0, -1, 1'b1, bad);
        checkOutput("sb_seq", 128'(bad), 128'(0));
        runGap(10, 1'b0);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (mem[i] !== src[i]) bad++;
        end
        checkOutput("sb_contents", 128'(bad), 128'(0));
        checkOutput("sb_writes", 128'(writeCount - baseW), 128'(TOTAL));
        checkOutput("sb_starts", 128'(startCount - baseS), 128'(1));
        checkOutput("write_shape", 128'(shapeBad), 128'(0));

        $display("[TB] GAP_CYC=1 instance");
        iLoad2 = 1'b1;
        @(negedge clk);
        iLoad2 = 1'b0;
        checkOutput("g1_ready", 128'(oReady2), 128'(1));
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            iValid2 = 1'b1;
            iData2  = 128'(k + 100);
            @(negedge clk);
            expEna2 = 2'(1) << (k / 4);
            if ((o_wea2 !== expEna2) || (o_ena2 !== expEna2) ||
                (o_addra2 !== 9'(k % 4)) || (o_dia2 !== 128'(k + 100))) begin
                bad++;
            end
        end
        iValid2 = 1'b0;
        checkOutput("g1_seq", 128'(bad), 128'(0));
        checkOutput("g1_last_ena", 128'(o_ena2), 128'(2'b10));
        checkOutput("g1_no_start_yet", 128'(oStart2), 128'(0));
        @(negedge clk);
        checkOutput("g1_start", 128'(oStart2), 128'(1));
        checkOutput("g1_wea_idle", 128'(o_wea2), 128'(0));
        @(negedge clk);
        checkOutput("g1_start_clear", 128'(oStart2), 128'(0));
        checkOutput("g1_idle", 128'(oBusy2), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
